// File: rtl/sevenseg_scan_if.sv
// Display-driver bus: data/config inputs from the system side, display pins from the driver.
interface sevenseg_scan_if #(
  parameter int unsigned NDIGITS = 4
);
  logic                   en;
  logic                   load;
  logic [4*NDIGITS-1:0]   din;
  logic [NDIGITS-1:0]     dp_in;
  logic                   blank_lz;
  logic [6:0]             seg_n;
  logic                   dp_n;
  logic [NDIGITS-1:0]     an_n;
  logic                   frame;

  modport master (
    output en, load, din, dp_in, blank_lz,
    input  seg_n, dp_n, an_n, frame
  );

  modport slave (
    input  en, load, din, dp_in, blank_lz,
    output seg_n, dp_n, an_n, frame
  );
endinterface

// File: rtl/sevenseg_scan.sv
// Time-multiplexed N-digit seven-segment driver with inter-digit dark gap
// and optional leading-zero blanking. All display outputs are registered.
module sevenseg_scan #(
   parameter int unsigned NDIGITS  = 4,
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned GAP_CYC  = 16
) (
   input logic            clk,
   input logic            rst_n,
   sevenseg_scan_if.slave bus
);

   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);
   // Signed copy so a zero gap does not produce a constant unsigned compare.
   localparam int GAP = int'(GAP_CYC);

   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [4*NDIGITS-1:0] sh_d_q;
   logic [NDIGITS-1:0]   sh_dp_q;
   logic [6:0]           seg_q, seg_d;
   logic                 dp_q, dp_d;
   logic [NDIGITS-1:0]   an_q, an_d;
   logic                 frame_q, frame_d;

   logic [3:0]           nib;
   logic                 dp_sel;
   logic                 blank;
   logic                 show;
   logic [NDIGITS-1:0]   allz;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h58;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (!bus.en) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // allz[i]: nibbles i..NDIGITS-1 of the shadow are all zero.
   always_comb begin
      logic run;
      run = 1'b1;
      allz = '0;
      for (int i = NDIGITS - 1; i >= 0; i--) begin
         run = run && (sh_d_q[4*i +: 4] == 4'h0);
         allz[i] = run;
      end
   end

   always_comb begin
      nib    = 4'h0;
      dp_sel = 1'b0;
      blank  = 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            nib    = sh_d_q[4*i +: 4];
            dp_sel = sh_dp_q[i];
            blank  = bus.blank_lz && (i != 0) && allz[i];
         end
      end
   end

   always_comb begin
      show    = bus.en && (int'({1'b0, cnt_q}) >= GAP);
      seg_d   = 7'h7F;
      dp_d    = 1'b1;
      an_d    = '1;
      frame_d = bus.en && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
      if (show) begin
         seg_d = blank ? 7'h7F : glyph(nib);
         dp_d  = ~dp_sel;
         for (int i = 0; i < NDIGITS; i++) begin
            an_d[i] = (idx_q != IW'(i));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_d_q  <= '0;
         sh_dp_q <= '0;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         an_q    <= '1;
         frame_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         if (bus.load) begin
            sh_d_q  <= bus.din;
            sh_dp_q <= bus.dp_in;
         end
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
         frame_q <= frame_d;
      end
   end

   assign bus.seg_n = seg_q;
   assign bus.dp_n  = dp_q;
   assign bus.an_n  = an_q;
   assign bus.frame = frame_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan: main 4-digit instance plus a 1-digit corner instance.
module tb_sevenseg_scan;

   logic clk;
   logic rst_n;
   logic rst2_n;

   sevenseg_scan_if #(.NDIGITS(4)) bus ();
   sevenseg_scan_if #(.NDIGITS(1)) bus2 ();

   sevenseg_scan #(.NDIGITS(4), .SCAN_DIV(8), .GAP_CYC(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   sevenseg_scan #(.NDIGITS(1), .SCAN_DIV(2), .GAP_CYC(0)) dut2 (
      .clk   (clk),
      .rst_n (rst2_n),
      .bus   (bus2)
   );

   typedef struct {
      string       tag;
      int          which;
      logic [12:0] v;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_out(input string tag, input int which, input logic [6:0] seg,
                             input logic dp, input logic [3:0] an, input logic fr);
      exp_t e;
      e.tag   = tag;
      e.which = which;
      e.v     = {seg, dp, an, fr};
      sb.push_back(e);
   endtask

   task automatic compare_out();
      exp_t        e;
      logic [12:0] obs;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL scoreboard: observed=empty queue expected=entry");
         return;
      end
      e = sb.pop_front();
      if (e.which == 0) obs = {bus.seg_n, bus.dp_n, bus.an_n, bus.frame};
      else              obs = {bus2.seg_n, bus2.dp_n, 3'b000, bus2.an_n, bus2.frame};
      assert (obs === e.v) else begin
         bad++;
         $display("FAIL %s: observed seg/dp/an/fr=%h/%b/%h/%b expected=%h/%b/%h/%b", e.tag,
                  obs[12:6], obs[5], obs[4:1], obs[0], e.v[12:6], e.v[5], e.v[4:1], e.v[0]);
         $error("check %s", e.tag);
      end
   endtask

   // Push expectation, advance one edge, compare; load strobes are one-shot.
   task automatic tick(input string tag, input int which, input logic [6:0] seg,
                       input logic dp, input logic [3:0] an, input logic fr);
      expect_out(tag, which, seg, dp, an, fr);
      @(posedge clk);
      #1;
      bus.load  = 1'b0;
      bus2.load = 1'b0;
      compare_out();
   endtask

   // Cycles c0..c1 of the slot for digit d on the main instance.
   task automatic slot(input string tag, input int d, input logic [6:0] seg, input logic dpl,
                       input int c0, input int c1);
      logic [3:0] an;
      an = ~(4'b0001 << d);
      for (int c = c0; c <= c1; c++) begin
         if (c < 2) tick(tag, 0, 7'h7F, 1'b1, 4'hF, 1'b0);
         else       tick(tag, 0, seg, ~dpl, an, (d == 3) && (c == 7));
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      rst2_n        = 1'b0;
      bus.en        = 1'b0;
      bus.load      = 1'b0;
      bus.din       = '0;
      bus.dp_in     = '0;
      bus.blank_lz  = 1'b0;
      bus2.en       = 1'b0;
      bus2.load     = 1'b0;
      bus2.din      = '0;
      bus2.dp_in    = '0;
      bus2.blank_lz = 1'b0;

      tick("reset", 0, 7'h7F, 1'b1, 4'hF, 1'b0);
      tick("reset", 0, 7'h7F, 1'b1, 4'hF, 1'b0);
      rst_n = 1'b1;
      tick("idle", 0, 7'h7F, 1'b1, 4'hF, 1'b0);

      // Two full frames of 1A3F with dp on digit 2.
      bus.din   = 16'h1A3F;
      bus.dp_in = 4'b0100;
      bus.load  = 1'b1;
      bus.en    = 1'b1;
      for (int f = 0; f < 2; f++) begin
         slot("frame_d0", 0, 7'h0E, 1'b0, 0, 7);
         slot("frame_d1", 1, 7'h30, 1'b0, 0, 7);
         slot("frame_d2", 2, 7'h08, 1'b1, 0, 7);
         slot("frame_d3", 3, 7'h79, 1'b0, 0, 7);
      end

      // Leading-zero blanking; blanked digit 3 still shows its decimal point.
      bus.din      = 16'h0070;
      bus.dp_in    = 4'b1000;
      bus.blank_lz = 1'b1;
      bus.load     = 1'b1;
      slot("lz_d0", 0, 7'h40, 1'b0, 0, 7);
      slot("lz_d1", 1, 7'h58, 1'b0, 0, 7);
      slot("lz_d2", 2, 7'h7F, 1'b0, 0, 7);
      slot("lz_d3", 3, 7'h7F, 1'b1, 0, 7);

      bus.din   = 16'h0000;
      bus.dp_in = 4'b0000;
      bus.load  = 1'b1;
      slot("lz0_d0", 0, 7'h40, 1'b0, 0, 7);
      slot("lz0_d1", 1, 7'h7F, 1'b0, 0, 7);
      slot("lz0_d2", 2, 7'h7F, 1'b0, 0, 7);
      slot("lz0_d3", 3, 7'h7F, 1'b0, 0, 7);

      // Live load during digit-0 SHOW.
      bus.blank_lz = 1'b0;
      bus.din      = 16'h0008;
      bus.load     = 1'b1;
      slot("live_pre", 0, 7'h00, 1'b0, 0, 3);
      bus.din  = 16'h0005;
      bus.load = 1'b1;
      slot("live_old", 0, 7'h00, 1'b0, 4, 4);
      slot("live_new", 0, 7'h12, 1'b0, 5, 7);
      slot("live_d1", 1, 7'h40, 1'b0, 0, 3);

      // Enable dropped mid-slot, then restored.
      bus.en = 1'b0;
      for (int k = 0; k < 5; k++) tick("en_off", 0, 7'h7F, 1'b1, 4'hF, 1'b0);
      bus.en = 1'b1;
      slot("en_on_d0", 0, 7'h12, 1'b0, 0, 7);
      slot("en_on_d1", 1, 7'h40, 1'b0, 0, 3);

      // Asynchronous reset mid-SHOW.
      rst_n = 1'b0;
      #1;
      expect_out("rst_async", 0, 7'h7F, 1'b1, 4'hF, 1'b0);
      compare_out();
      tick("rst_hold", 0, 7'h7F, 1'b1, 4'hF, 1'b0);
      rst_n = 1'b1;
      slot("rst_resume", 0, 7'h40, 1'b0, 0, 7);

      // Corner instance: one digit, two-cycle slot, no gap.
      rst2_n     = 1'b1;
      bus2.din   = 4'h8;
      bus2.dp_in = 1'b1;
      bus2.load  = 1'b1;
      tick("corner_idle", 1, 7'h7F, 1'b1, 4'b0001, 1'b0);
      bus2.en = 1'b1;
      for (int k = 0; k < 6; k++) tick("corner_run", 1, 7'h00, 1'b0, 4'b0000, (k % 2) == 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Parametrised, time-multiplexed N-digit seven-segment display driver. It holds a shadow copy of N hex nibbles and per-digit decimal points, and scans one digit at a time onto shared active-low segment lines and active-low digit anodes. Between digits it inserts a dark gap to prevent ghosting, and it can optionally blank leading zeros. It sits between the system's output registers and the board's display pins, and replaces per-digit static decoding.

## Interface
- NDIGITS, 4: number of digits; legal range 1..8.
- SCAN_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- GAP_CYC, 16: dark cycles at the start of each slot; legal range 0..SCAN_DIV-1.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable.
- load  in  1  capture strobe for din and dp_in.
- din  in  4*NDIGITS  hex nibbles; digit i is din[4i+3:4i]; digit 0 is rightmost.
- dp_in  in  NDIGITS  decimal point per digit; 1 = lit.
- blank_lz  in  1  leading-zero blanking enable; static configuration, used live.
- seg_n  out  7  segments, bit6=g .. bit0=a; 0 = lit.
- dp_n  out  1  decimal point; 0 = lit.
- an_n  out  NDIGITS  digit anodes; 0 = selected.
- frame  out  1  one-cycle pulse when the last digit slot completes.

## Operation
- **Shadow registers.** sh_d (4*NDIGITS bits) and sh_dp (NDIGITS bits) are loaded from din and dp_in on every clk edge with load=1. Otherwise they hold.
- **Scan state.**
  - cnt runs 0..SCAN_DIV-1. idx runs 0..NDIGITS-1.
  - When en=1, cnt increments each cycle. At cnt=SCAN_DIV-1, cnt goes to 0 and idx advances modulo NDIGITS.
  - When en=0, cnt and idx are forced to 0.
- **Per-slot phases (function of cnt).**
  - GAP phase: cnt < GAP_CYC. Display dark.
  - SHOW phase: otherwise. Digit idx is driven.
- **Glyphs (active-low, hex 7-bit).**
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→58.
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- **Leading-zero blanking.**
  - Digit i ≥ 1 is blanked when blank_lz=1 and nibbles i..NDIGITS-1 of sh_d are all zero.
  - A blanked digit forces seg_n=7F. Its anode is still selected, and dp_n still follows sh_dp[i].
  - Digit 0 is never blanked.
- **Output registers.** Every cycle, seg_n, dp_n, an_n and frame are computed from the current cnt, idx, sh_d, sh_dp, en and blank_lz, then registered.
  - en=0 or GAP phase: an_n all 1, seg_n=7F, dp_n=1.
  - SHOW phase: an_n has only bit idx at 0; seg_n is the glyph of nibble idx (or 7F if blanked); dp_n = ~sh_dp[idx].
  - frame=1 for exactly one cycle when en=1, cnt=SCAN_DIV-1 and idx=NDIGITS-1.
- **Reset values (asynchronous, rst_n=0).**
  - Outputs: seg_n=7F, dp_n=1, an_n all 1, frame=0.
  - State: cnt=0, idx=0, sh_d=0, sh_dp=0.
- **Width rules.**
  - cnt width is clog2(SCAN_DIV).
  - idx width is max(1, clog2(NDIGITS)).
  - NDIGITS=1: idx stays 0 and frame pulses at the end of every slot.

## Timing
- **Latency.** Outputs reflect state one cycle late. A load at edge k changes sh_d at edge k; the new glyph appears on seg_n at edge k+1 if that digit is in SHOW phase.
- **Load during a slot.** Takes effect immediately; there is no wait for the frame boundary.
- **Simultaneous load and slot change.** The new data is used for the new digit.
- **Slot sequence.** With GAP_CYC=G, each slot shows G cycles with an_n all 1, then SCAN_DIV-G cycles with one anode low. G=0 means no gap.
- **Full frame.** Lasts NDIGITS*SCAN_DIV cycles. frame pulses are exactly that far apart while en=1.
- **en falling.** The display is dark from the next edge.
- **en rising.** Scanning restarts at digit 0, cnt=0, beginning with a GAP phase.
- **Reset mid-scan.** Outputs go dark immediately (asynchronous). After rst_n releases, scanning resumes at digit 0 on the next edge with en=1. Shadow contents are lost.
- **Wrap-around.** idx=NDIGITS-1 advances to 0, with no extra gap beyond GAP_CYC.
- **Anodes.** Never more than one an_n bit is 0 in any cycle.

## Test plan
Bench uses NDIGITS=4, SCAN_DIV=8, GAP_CYC=2 unless stated.

- **Reset.** Assert rst_n=0 mid-SHOW with load done → same cycle seg_n=7F, an_n=F, dp_n=1, frame=0. After release with en=1: 2 dark cycles, then an_n=E.
- **Full frame.** load din=16'h1A3F, dp_in=4'b0100, blank_lz=0, en=1 → slots in order:
  - digit 0: seg_n=0E, an_n=E
  - digit 1: seg_n=30, an_n=D
  - digit 2: seg_n=08, an_n=B, dp_n=0
  - digit 3: seg_n=79, an_n=7
  - each slot: 2 dark plus 6 lit cycles; frame pulses every 32 cycles.
- **Leading-zero blanking.** din=16'h0070, blank_lz=1 → digits 3 and 2 show seg_n=7F with anode low; digit 1 shows 58; digit 0 shows 40. With din=0, only digit 0 shows 40.
- **Live load.** load din=16'h0005 during digit-0 SHOW → seg_n changes from the old glyph to 12 exactly one edge later; an_n is unchanged.
- **Enable.** Drop en mid-slot for 5 cycles → dark from the next edge and frame=0. On re-enable, scan restarts at digit 0 with 2 gap cycles.
- **Corner parameters.** NDIGITS=1, SCAN_DIV=2, GAP_CYC=0 → an_n=0 constantly after the first edge; frame pulses every 2 cycles.
